// File: rtl/sat_decision_pkg.sv
// rtl/sat_decision_pkg.sv - shared types and index helpers for the decision unit
// Contents: FSM state encoding, clog2, and helpers that split a variable index
// into a bitmap word index and a bit-within-word index.
package sat_decision_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SCAN      = 2'd1,
      ST_WRITEBACK = 2'd2,
      ST_REPORT    = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int word_of(input int idx, input int word_w);
      return idx >> clog2(word_w);
   endfunction

   function automatic int bit_of(input int idx, input int word_w);
      return idx & (word_w - 1);
   endfunction

endpackage

// File: rtl/sat_decision_unit_priority_encoder.sv
// rtl/sat_decision_unit_priority_encoder.sv - lowest-set-bit encoder for one bitmap word
// Ports:
//   word   in  WORD_W         bitmap word to encode
//   index  out clog2(WORD_W)  position of the lowest set bit (0 when none)
//   any    out 1              at least one bit of word is set
module priority_encoder_param
   import sat_decision_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic [WORD_W-1:0]        word,
   output logic [clog2(WORD_W)-1:0] index,
   output logic                     any
);

   localparam int IDX_W = clog2(WORD_W);

   // Walk from the top down so the last hit, the lowest set bit, wins.
   always_comb begin
      index = '0;
      any   = 1'b0;
      for (int i = WORD_W - 1; i >= 0; i--) begin
         if (word[i]) begin
            index = IDX_W'(i);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sat_decision_unit.sv
// rtl/sat_decision_unit.sv - decision engine picking the lowest free variable
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   decision_en                   request a decision (IDLE only)
//   clear_en                      mark every variable free, phases to default (IDLE only)
//   release_en, release_var,
//   release_phase                 free one variable and save its phase (IDLE only)
//   busy                          engine is not in IDLE
//   decision_done                 one-cycle completion pulse
//   var_out, assignment           chosen variable and its polarity
//   no_free                       last request found every variable assigned
module sat_decision_unit
   import sat_decision_pkg::*;
#(
   parameter int   WORD_W           = 8,
   parameter int   NUM_WORDS        = 4,
   parameter int   VAR_IDX_W        = 5,
   parameter int   POLARITY_MODE    = 0,
   parameter logic DEFAULT_POLARITY = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 decision_en,
   input  logic                 clear_en,
   input  logic                 release_en,
   input  logic [VAR_IDX_W-1:0] release_var,
   input  logic                 release_phase,
   output logic                 busy,
   output logic                 decision_done,
   output logic [VAR_IDX_W-1:0] var_out,
   output logic                 assignment,
   output logic                 no_free
);

   localparam int NUM_VARS = WORD_W * NUM_WORDS;
   localparam int BIT_W    = clog2(WORD_W);
   localparam int WIDX_W   = VAR_IDX_W - BIT_W;
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

   state_t state_q, state_d;

   logic [WORD_W-1:0]   free_q [NUM_WORDS];
   logic [NUM_VARS-1:0] phase_q;
   logic [WIDX_W-1:0]   hint_q;
   logic [WIDX_W-1:0]   ptr_q;
   logic [BIT_W-1:0]    bit_q;
   logic                found_q;

   logic [BIT_W-1:0]     enc_index;
   logic                 enc_any;
   logic [WIDX_W-1:0]    rel_word;
   logic [BIT_W-1:0]     rel_bit;
   logic [WIDX_W-1:0]    rel_hint;
   logic [WORD_W-1:0]    word_after;
   logic [VAR_IDX_W-1:0] chosen;

   priority_encoder_param #(.WORD_W(WORD_W)) u_encoder (
      .word  (free_q[ptr_q]),
      .index (enc_index),
      .any   (enc_any)
   );

   assign rel_word   = WIDX_W'(word_of(int'(release_var), WORD_W));
   assign rel_bit    = BIT_W'(bit_of(int'(release_var), WORD_W));
   assign rel_hint   = (rel_word < hint_q) ? rel_word : hint_q;
   assign word_after = free_q[ptr_q] & ~(WORD_W'(1) << bit_q);
   assign chosen     = {ptr_q, bit_q};

   assign busy          = (state_q != ST_IDLE);
   assign decision_done = (state_q == ST_REPORT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // An exhausted scan still passes through WRITEBACK (with nothing to write)
   // so that both outcomes publish their results from the same state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (decision_en) state_d = ST_SCAN;
         ST_SCAN:      if (enc_any || ptr_q == LAST_WORD) state_d = ST_WRITEBACK;
         ST_WRITEBACK: state_d = ST_REPORT;
         ST_REPORT:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WORDS; w++) free_q[w] <= '1;
         phase_q    <= {NUM_VARS{DEFAULT_POLARITY}};
         hint_q     <= '0;
         ptr_q      <= '0;
         bit_q      <= '0;
         found_q    <= 1'b0;
         var_out    <= '0;
         assignment <= DEFAULT_POLARITY;
         no_free    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The bitmap update and the scan start share this edge, so the
               // scan sees the cleared/released state from its first cycle.
               if (clear_en) begin
                  for (int w = 0; w < NUM_WORDS; w++) free_q[w] <= '1;
                  phase_q <= {NUM_VARS{DEFAULT_POLARITY}};
                  hint_q  <= '0;
                  no_free <= 1'b0;
                  if (decision_en) ptr_q <= '0;
               end else if (release_en) begin
                  free_q[rel_word][rel_bit] <= 1'b1;
                  phase_q[release_var]      <= release_phase;
                  hint_q                    <= rel_hint;
                  if (decision_en) ptr_q <= rel_hint;
               end else if (decision_en) begin
                  ptr_q <= hint_q;
               end
            end
            ST_SCAN: begin
               found_q <= enc_any;
               if (enc_any)                 bit_q <= enc_index;
               else if (ptr_q != LAST_WORD) ptr_q <= ptr_q + 1'b1;
            end
            ST_WRITEBACK: begin
               if (found_q) begin
                  free_q[ptr_q][bit_q] <= 1'b0;
                  if (word_after == '0 && ptr_q != LAST_WORD) hint_q <= ptr_q + 1'b1;
                  else                                        hint_q <= ptr_q;
                  var_out    <= chosen;
                  assignment <= (POLARITY_MODE == 1) ? phase_q[chosen] : DEFAULT_POLARITY;
                  no_free    <= 1'b0;
               end else begin
                  no_free <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
